conv1_maxpool: RTL and testbench



---
 rtl/cnn_pkg.sv | 26 ++
 rtl/conv1_maxpool_if.sv | 24 ++
 rtl/pool_row_buffer.sv | 21 ++
 rtl/conv1_maxpool.sv | 114 +++++++++++
 tb/tb_conv1_maxpool.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN constants: first-layer geometry, data widths and the
// ReLU + shift + unsigned-saturate requantiser used between layers.
package cnn_pkg;

  localparam int unsigned IMG_W         = 28;
  localparam int unsigned FILTER_SIZE   = 7;
  localparam int unsigned CONV1_W       = IMG_W - FILTER_SIZE + 1;
  localparam int unsigned CONV1_H       = CONV1_W;
  localparam int unsigned DATA_BITS     = 8;
  localparam int unsigned CONV_ACC_BITS = 23;
  localparam int unsigned REQ_SHIFT     = 8;

  // Negative -> 0; otherwise x >> shift clipped to the unsigned pixel range.
  function automatic logic [DATA_BITS-1:0] requant_sat(
    input logic signed [CONV_ACC_BITS-1:0] x,
    input int unsigned                     shift
  );
    logic [CONV_ACC_BITS-1:0] mag;
    mag = '0;
    if (x[CONV_ACC_BITS-1]) return '0;
    mag = $unsigned(x) >> shift;
    if (|mag[CONV_ACC_BITS-1:DATA_BITS]) return '1;
    return mag[DATA_BITS-1:0];
  endfunction

endpackage

// File: rtl/conv1_maxpool_if.sv
// Stream signals between the conv calculator, the max-pool stage and the
// next layer's line buffer. slave = pool stage, master = its environment.
interface conv1_maxpool_if #(
  parameter int unsigned IN_BITS   = cnn_pkg::CONV_ACC_BITS,
  parameter int unsigned DATA_BITS = cnn_pkg::DATA_BITS
);
  logic signed [IN_BITS-1:0] conv_out_1;
  logic                      valid_out_calc;
  logic                      maxpool_ready;
  logic [DATA_BITS-1:0]      pool_out;
  logic                      valid_out_pool;
  logic                      pool_ready_in;
  logic                      frame_done;

  modport master (
    output conv_out_1, valid_out_calc, pool_ready_in,
    input  maxpool_ready, pool_out, valid_out_pool, frame_done
  );

  modport slave (
    input  conv_out_1, valid_out_calc, pool_ready_in,
    output maxpool_ready, pool_out, valid_out_pool, frame_done
  );
endinterface

// File: rtl/pool_row_buffer.sv
// Holds the horizontal maxima of an even pooling row until the odd row
// reads them back. Written before read every frame, so it has no reset.
module pool_row_buffer #(
  parameter int unsigned DEPTH  = 11,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/conv1_maxpool.sv
// ReLU/requantise the first conv layer's raster stream and 2x2 stride-2
// max-pool it into a held, backpressured pixel stream.
module conv1_maxpool #(
  parameter int unsigned CONV_WIDTH  = cnn_pkg::CONV1_W,
  parameter int unsigned CONV_HEIGHT = cnn_pkg::CONV1_H,
  parameter int unsigned IN_BITS     = cnn_pkg::CONV_ACC_BITS,
  parameter int unsigned DATA_BITS   = cnn_pkg::DATA_BITS,
  parameter int unsigned SHIFT       = cnn_pkg::REQ_SHIFT
) (
  input logic            clk,
  input logic            rst_n,
  conv1_maxpool_if.slave bus
);
  import cnn_pkg::*;

  localparam int unsigned COL_W  = $clog2(CONV_WIDTH);
  localparam int unsigned ROW_W  = $clog2(CONV_HEIGHT);
  localparam int unsigned POOL_W = CONV_WIDTH / 2;
  localparam int unsigned ADDR_W = (POOL_W > 1) ? $clog2(POOL_W) : 1;

  logic [COL_W-1:0]     col_q, col_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [DATA_BITS-1:0] hmax_q, hmax_d;
  logic [DATA_BITS-1:0] pool_out_q, pool_out_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;

  logic                 ready_c, accept, pool_load, rb_we;
  logic                 col_last, row_last;
  logic [ADDR_W-1:0]    rb_addr;
  logic [DATA_BITS-1:0] r, p, q, rb_rdata;

  // Stall only while a pooled pixel is held and downstream refuses it.
  assign ready_c   = !(valid_q && !bus.pool_ready_in);
  assign accept    = bus.valid_out_calc && ready_c;
  assign col_last  = (col_q == COL_W'(CONV_WIDTH - 1));
  assign row_last  = (row_q == ROW_W'(CONV_HEIGHT - 1));

  assign r = DATA_BITS'(requant_sat(CONV_ACC_BITS'(bus.conv_out_1), SHIFT));
  assign p = (r > hmax_q) ? r : hmax_q;
  assign q = (rb_rdata > p) ? rb_rdata : p;

  // Odd columns close a horizontal pair; odd rows close the 2x2 window.
  assign rb_addr   = ADDR_W'(col_q >> 1);
  assign rb_we     = accept && col_q[0] && !row_q[0];
  assign pool_load = accept && col_q[0] && row_q[0];

  pool_row_buffer #(
    .DEPTH  (POOL_W),
    .WIDTH  (DATA_BITS),
    .ADDR_W (ADDR_W)
  ) u_row_buffer (
    .clk   (clk),
    .we    (rb_we),
    .addr  (rb_addr),
    .wdata (p),
    .rdata (rb_rdata)
  );

  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    hmax_d     = hmax_q;
    pool_out_d = pool_out_q;
    valid_d    = valid_q;
    done_d     = 1'b0;

    if (accept) begin
      if (!col_q[0]) hmax_d = r;
      if (col_last) begin
        col_d = '0;
        if (row_last) begin
          row_d  = '0;
          done_d = 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    // A fresh load wins over a same-cycle drain.
    if (pool_load) begin
      pool_out_d = q;
      valid_d    = 1'b1;
    end else if (bus.pool_ready_in) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      hmax_q     <= '0;
      pool_out_q <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      hmax_q     <= hmax_d;
      pool_out_q <= pool_out_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
    end
  end

  assign bus.maxpool_ready  = ready_c;
  assign bus.pool_out       = pool_out_q;
  assign bus.valid_out_pool = valid_q;
  assign bus.frame_done     = done_q;
endmodule

// File: tb/tb_conv1_maxpool.sv
// Directed bench for conv1_maxpool: ramp frames, requant corners,
// backpressure, sparse valid, mid-frame reset and back-to-back loading.
module tb_conv1_maxpool;
  import cnn_pkg::*;

  localparam int unsigned W = 22;
  localparam int unsigned H = 22;
  localparam int unsigned N_IN  = W * H;
  localparam int unsigned N_OUT = (W / 2) * (H / 2);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv1_maxpool_if #(.IN_BITS(23), .DATA_BITS(8)) bus ();

  conv1_maxpool #(
    .CONV_WIDTH (W), .CONV_HEIGHT (H), .IN_BITS (23), .DATA_BITS (8), .SHIFT (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [7:0] got[$];
  int fd_cnt = 0;

  // Record every pooled pixel handed downstream and every frame_done pulse.
  always @(negedge clk) begin
    if (rst_n && bus.valid_out_pool && bus.pool_ready_in) got.push_back(bus.pool_out);
    if (rst_n && bus.frame_done) fd_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Ramp window (i,j) maximum is its bottom-right sample, clipped to 255.
  function automatic logic [7:0] exp_ramp(input int k);
    int i, j, v;
    i = k / int'(W / 2);
    j = k % int'(W / 2);
    v = (2 * i + 1) * int'(W) + 2 * j + 1;
    return (v > 255) ? 8'd255 : 8'(v);
  endfunction

  function automatic logic signed [22:0] ramp_x(input int idx);
    return 23'(idx << 8);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.valid_out_calc = 1'b0;
    bus.conv_out_1 = '0;
    bus.pool_ready_in = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Offer one sample after 'gap' idle cycles; returns #1 after its accept edge.
  task automatic send(input logic signed [22:0] x, input int gap);
    logic rdy;
    bit   sent;
    sent = 1'b0;
    bus.valid_out_calc = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.conv_out_1 = x;
    bus.valid_out_calc = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      rdy = bus.maxpool_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        sent = 1'b1;
        break;
      end
    end
    if (!sent) begin
      chk_cnt++;
      $display("FAIL send_timeout: sample 0x%06h never accepted", x);
    end
    bus.valid_out_calc = 1'b0;
  endtask

  task automatic drain();
    repeat (4) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.valid_out_calc = 1'b0;
    bus.conv_out_1 = '0;
    bus.pool_ready_in = 1'b0;
    #12;
    chk_cnt++;
    if (bus.maxpool_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.maxpool_ready);
    else pass_cnt++;
    chk_cnt++;
    if (bus.valid_out_pool !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.valid_out_pool);
    else pass_cnt++;
    chk_cnt++;
    if (bus.pool_out !== 8'd0) $display("FAIL reset_pool_out: got %0d want 0", bus.pool_out);
    else pass_cnt++;
    chk_cnt++;
    if (bus.frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", bus.frame_done);
    else pass_cnt++;
  endtask

  task automatic test_ramp();
    do_reset();
    got.delete();
    fd_cnt = 0;
    for (int idx = 0; idx < int'(N_IN); idx++) send(ramp_x(idx), 0);
    @(negedge clk);
    chk_cnt++;
    if (bus.frame_done !== 1'b1) $display("FAIL ramp_frame_done: got %b want 1", bus.frame_done);
    else pass_cnt++;
    drain();
    chk_cnt++;
    if (got.size() != int'(N_OUT)) $display("FAIL ramp_count: got %0d want %0d", got.size(), N_OUT);
    else pass_cnt++;
    for (int k = 0; k < got.size() && k < int'(N_OUT); k++) begin
      chk_cnt++;
      if (got[k] !== exp_ramp(k)) $display("FAIL ramp_px%0d: got %0d want %0d", k, got[k], exp_ramp(k));
      else pass_cnt++;
    end
    chk_cnt++;
    if (fd_cnt != 1) $display("FAIL ramp_fd_count: got %0d want 1", fd_cnt);
    else pass_cnt++;
  endtask

  task automatic test_relu_sat();
    logic [7:0] exp_tab[11] = '{8'd0, 8'd255, 8'd3, 8'd16, 8'd33, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    logic signed [22:0] x;
    do_reset();
    got.delete();
    for (int rr = 0; rr < 2; rr++) begin
      for (int cc = 0; cc < int'(W); cc++) begin
        x = '0;
        case ({rr[0], 5'(cc)})
          {1'b0, 5'd0}: x = 23'(-5000);
          {1'b0, 5'd1}: x = 23'(-1);
          {1'b1, 5'd0}: x = 23'(-300);
          {1'b1, 5'd1}: x = 23'(-7);
          {1'b0, 5'd3}: x = 23'h3FFFFF;   // largest positive 23-bit value
          {1'b0, 5'd4}: x = 23'd256;
          {1'b0, 5'd5}: x = 23'd512;
          {1'b1, 5'd4}: x = 23'd768;
          {1'b1, 5'd5}: x = 23'd1023;
          {1'b0, 5'd6}: x = 23'd4096;
          {1'b1, 5'd8}: x = 23'd8448;
          default:      x = '0;
        endcase
        send(x, 0);
      end
    end
    drain();
    chk_cnt++;
    if (got.size() != 11) $display("FAIL relu_count: got %0d want 11", got.size());
    else pass_cnt++;
    for (int k = 0; k < got.size() && k < 11; k++) begin
      chk_cnt++;
      if (got[k] !== exp_tab[k]) $display("FAIL relu_px%0d: got %0d want %0d", k, got[k], exp_tab[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    logic seen;
    do_reset();
    got.delete();
    fd_cnt = 0;
    bus.pool_ready_in = 1'b0;
    seen = 1'b0;
    fork
      for (int idx = 0; idx < int'(N_IN); idx++) send(ramp_x(idx), 0);
      begin
        for (int k = 0; k < 200; k++) begin
          @(negedge clk);
          if (bus.valid_out_pool) begin
            seen = 1'b1;
            break;
          end
        end
        chk_cnt++;
        if (!seen) $display("FAIL bp_first_output: got none want valid within 200 cycles");
        else pass_cnt++;
        for (int k = 0; k < 5; k++) begin
          if (k > 0) @(negedge clk);
          chk_cnt++;
          if (bus.maxpool_ready !== 1'b0) $display("FAIL bp_ready_c%0d: got %b want 0", k, bus.maxpool_ready);
          else pass_cnt++;
          chk_cnt++;
          if (bus.valid_out_pool !== 1'b1 || bus.pool_out !== 8'd23)
            $display("FAIL bp_hold_c%0d: got v=%b px=%0d want v=1 px=23", k, bus.valid_out_pool, bus.pool_out);
          else pass_cnt++;
        end
        @(posedge clk);
        #1 bus.pool_ready_in = 1'b1;
      end
    join
    drain();
    chk_cnt++;
    if (got.size() != int'(N_OUT)) $display("FAIL bp_count: got %0d want %0d", got.size(), N_OUT);
    else pass_cnt++;
    for (int k = 0; k < got.size() && k < int'(N_OUT); k++) begin
      chk_cnt++;
      if (got[k] !== exp_ramp(k)) $display("FAIL bp_px%0d: got %0d want %0d", k, got[k], exp_ramp(k));
      else pass_cnt++;
    end
    chk_cnt++;
    if (fd_cnt != 1) $display("FAIL bp_fd_count: got %0d want 1", fd_cnt);
    else pass_cnt++;
  endtask

  task automatic test_sparse();
    do_reset();
    got.delete();
    fd_cnt = 0;
    for (int idx = 0; idx < int'(N_IN); idx++) send(ramp_x(idx), int'($urandom_range(0, 3)));
    drain();
    chk_cnt++;
    if (got.size() != int'(N_OUT)) $display("FAIL sparse_count: got %0d want %0d", got.size(), N_OUT);
    else pass_cnt++;
    for (int k = 0; k < got.size() && k < int'(N_OUT); k++) begin
      chk_cnt++;
      if (got[k] !== exp_ramp(k)) $display("FAIL sparse_px%0d: got %0d want %0d", k, got[k], exp_ramp(k));
      else pass_cnt++;
    end
    chk_cnt++;
    if (fd_cnt != 1) $display("FAIL sparse_fd_count: got %0d want 1", fd_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    for (int idx = 0; idx < 100; idx++) send(ramp_x(idx), 0);
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (bus.valid_out_pool !== 1'b0 || bus.maxpool_ready !== 1'b1)
      $display("FAIL rst100: got v=%b rdy=%b want v=0 rdy=1", bus.valid_out_pool, bus.maxpool_ready);
    else pass_cnt++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Leave a pooled pixel pending, then reset over it.
    for (int idx = 0; idx < 67; idx++) send(ramp_x(idx), 0);
    bus.pool_ready_in = 1'b0;
    send(ramp_x(67), 0);
    chk_cnt++;
    if (bus.valid_out_pool !== 1'b1 || bus.pool_out !== 8'd67)
      $display("FAIL rst_pending: got v=%b px=%0d want v=1 px=67", bus.valid_out_pool, bus.pool_out);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (bus.valid_out_pool !== 1'b0 || bus.maxpool_ready !== 1'b1 || bus.pool_out !== 8'd0)
      $display("FAIL rst_discard: got v=%b rdy=%b px=%0d want v=0 rdy=1 px=0",
               bus.valid_out_pool, bus.maxpool_ready, bus.pool_out);
    else pass_cnt++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.pool_ready_in = 1'b1;
    @(posedge clk);
    #1;
    got.delete();
    fd_cnt = 0;
    for (int idx = 0; idx < int'(N_IN); idx++) send(ramp_x(idx), 0);
    drain();
    chk_cnt++;
    if (got.size() != int'(N_OUT)) $display("FAIL rst_count: got %0d want %0d", got.size(), N_OUT);
    else pass_cnt++;
    for (int k = 0; k < got.size() && k < int'(N_OUT); k++) begin
      chk_cnt++;
      if (got[k] !== exp_ramp(k)) $display("FAIL rst_px%0d: got %0d want %0d", k, got[k], exp_ramp(k));
      else pass_cnt++;
    end
    chk_cnt++;
    if (fd_cnt != 1) $display("FAIL rst_fd_count: got %0d want 1", fd_cnt);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    time t0;
    do_reset();
    t0 = $time;
    for (int idx = 0; idx < 2 * int'(W); idx++) begin
      send(ramp_x(idx), 0);
      if (idx > int'(W)) begin
        chk_cnt++;
        if (idx % 2 == 1) begin
          if (bus.valid_out_pool !== 1'b1 || bus.pool_out !== exp_ramp((idx - int'(W)) / 2))
            $display("FAIL b2b_load%0d: got v=%b px=%0d want v=1 px=%0d", idx,
                     bus.valid_out_pool, bus.pool_out, exp_ramp((idx - int'(W)) / 2));
          else pass_cnt++;
        end else begin
          if (bus.valid_out_pool !== 1'b0)
            $display("FAIL b2b_drain%0d: got v=%b want 0", idx, bus.valid_out_pool);
          else pass_cnt++;
        end
      end
    end
    chk_cnt++;
    if ($time - t0 != 2 * W * 10) $display("FAIL b2b_rate: got %0t want %0d", $time - t0, 2 * W * 10);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_relu_sat();
    test_back_to_back();
    test_backpressure();
    test_sparse();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
